// File: rtl/sram_sp_access_ctrl.sv
// Single-port SRAM access controller: write/read arbitration, 1-cycle read latency tracking,
// credit-gated read issue and a small response FIFO. o_sram_rw encodes 1 = WRITE, 0 = READ.
module sram_sp_access_ctrl #(
   parameter int WORDWD    = 256,
   parameter int DWD       = 16,
   parameter int AWD       = $clog2(WORDWD),
   parameter int SIZE      = 16,
   parameter int RSP_DEPTH = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_wr_valid,
   output logic                      o_wr_ready,
   input  logic [AWD-1:0]            i_wr_addr,
   input  logic [SIZE-1:0][DWD-1:0]  i_wr_data,
   input  logic                      i_rd_valid,
   output logic                      o_rd_ready,
   input  logic [AWD-1:0]            i_rd_addr,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [SIZE-1:0][DWD-1:0]  o_rsp_data,
   output logic                      o_sram_rw,
   output logic                      o_sram_ce,
   output logic [AWD-1:0]            o_sram_addr,
   output logic [SIZE-1:0][DWD-1:0]  o_sram_wdata,
   input  logic [SIZE-1:0][DWD-1:0]  i_sram_rdata
);

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;
   localparam int   PW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int   CW       = $clog2(RSP_DEPTH + 1);

   logic                     wr_last;
   logic                     rd_inflight;
   logic [PW-1:0]            wptr;
   logic [PW-1:0]            rptr;
   logic [CW-1:0]            count;
   logic [SIZE-1:0][DWD-1:0] mem [RSP_DEPTH];

   logic          pop;
   logic          rd_ok;
   logic          wr_gnt;
   logic          rd_gnt;
   logic [CW+1:0] credit_use;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_rsp_valid = (count != '0);
   assign o_rsp_data  = mem[rptr];

   // A read may only issue if its data will have a FIFO slot, counting the one already in flight.
   always_comb begin
      pop        = o_rsp_valid & i_rsp_ready;
      credit_use = (CW+2)'(count) + (CW+2)'(rd_inflight) - (CW+2)'(pop);
      rd_ok      = credit_use < (CW+2)'(RSP_DEPTH);
      wr_gnt     = !i_rst && i_wr_valid && (!(i_rd_valid && rd_ok) || !wr_last);
      rd_gnt     = !i_rst && i_rd_valid && rd_ok && (!i_wr_valid || wr_last);
   end

   always_comb begin
      o_wr_ready   = wr_gnt;
      o_rd_ready   = rd_gnt;
      o_sram_ce    = wr_gnt | rd_gnt;
      o_sram_rw    = RW_READ;
      o_sram_addr  = '0;
      o_sram_wdata = '0;
      if (wr_gnt) begin
         o_sram_rw    = RW_WRITE;
         o_sram_addr  = i_wr_addr;
         o_sram_wdata = i_wr_data;
      end else if (rd_gnt) begin
         o_sram_addr  = i_rd_addr;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_last     <= 1'b0;
         rd_inflight <= 1'b0;
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
      end else begin
         if (wr_gnt)
            wr_last <= 1'b1;
         else if (rd_gnt)
            wr_last <= 1'b0;
         rd_inflight <= rd_gnt;
         if (rd_inflight)
            wptr <= next_ptr(wptr);
         if (pop)
            rptr <= next_ptr(rptr);
         case ({rd_inflight, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && rd_inflight)
         mem[wptr] <= i_sram_rdata;
   end

endmodule

// File: tb/tb_sram_sp_access_ctrl.sv
// Directed bench for sram_sp_access_ctrl with a behavioural 1-cycle-latency SRAM behind it.
module tb_sram_sp_access_ctrl;

   localparam int WORDWD    = 256;
   localparam int DWD       = 16;
   localparam int AWD       = 8;
   localparam int SIZE      = 16;
   localparam int RSP_DEPTH = 2;

   typedef logic [SIZE-1:0][DWD-1:0] vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           wr_valid, wr_ready, rd_valid, rd_ready;
   logic [AWD-1:0] wr_addr, rd_addr, sram_addr;
   vec_t           wr_data, rsp_data, sram_wdata, sram_rdata;
   logic           rsp_valid, rsp_ready, sram_rw, sram_ce;

   int   vectors = 0;
   int   miscompares = 0;
   vec_t rsp_q[$];
   vec_t mem [WORDWD];

   always #5 clk = ~clk;

   sram_sp_access_ctrl #(
      .WORDWD(WORDWD), .DWD(DWD), .AWD(AWD), .SIZE(SIZE), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_rd_valid(rd_valid), .o_rd_ready(rd_ready), .i_rd_addr(rd_addr),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
      .o_sram_rw(sram_rw), .o_sram_ce(sram_ce), .o_sram_addr(sram_addr),
      .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata)
   );

   // SRAM macro model: 1 = write, read data appears the cycle after the read
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_rw) mem[sram_addr] <= sram_wdata;
         else         sram_rdata     <= mem[sram_addr];
      end
   end

   // Response capture and FIFO overflow watch
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
      if (!rst && dut.rd_inflight) begin
         vectors++;
         if (int'(dut.count) == RSP_DEPTH && !(rsp_valid && rsp_ready)) begin
            miscompares++;
            $display("FAIL fifo_push_when_full count=%0d", dut.count);
         end
      end
   end

   function automatic vec_t pat(input int a);
      vec_t r;
      for (int l = 0; l < SIZE; l++) r[l] = DWD'(a * 256 + l * 16 + 3);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int a);
      wr_valid = 1'b1; wr_addr = AWD'(a); wr_data = pat(a);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = '0; rd_addr = '0;
      wr_data = '0; rsp_ready = 1'b0;
      tick(); tick();
      @(negedge clk);
      vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
      vectors++; if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_rd_ready got %b exp 0", rd_ready); end
      vectors++; if (sram_ce !== 1'b0) begin miscompares++; $display("FAIL rst_ce got %b exp 0", sram_ce); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
      tick();
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
         miscompares++; $display("FAIL first_tie got wr=%b rd=%b exp wr=1 rd=0", wr_ready, rd_ready); end
      tick();
      wr_valid = 1'b0; rd_valid = 1'b0;
   endtask

   task automatic test_write_read();
      vec_t exp_v;
      exp_v = {SIZE{16'hA5A5}};
      wr_valid = 1'b1; wr_addr = 8'd3; wr_data = exp_v;
      @(negedge clk);
      vectors++; if (wr_ready !== 1'b1 || sram_ce !== 1'b1 || sram_rw !== 1'b1 || sram_addr !== 8'd3) begin
         miscompares++; $display("FAIL wr_drive got rdy=%b ce=%b rw=%b addr=%0d exp 1 1 1 3", wr_ready, sram_ce, sram_rw, sram_addr); end
      vectors++; if (sram_wdata !== exp_v) begin miscompares++; $display("FAIL wr_wdata got %h exp %h", sram_wdata, exp_v); end
      tick();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 8'd3;
      @(negedge clk);
      vectors++; if (rd_ready !== 1'b1 || sram_ce !== 1'b1 || sram_rw !== 1'b0 || sram_addr !== 8'd3) begin
         miscompares++; $display("FAIL rd_drive got rdy=%b ce=%b rw=%b addr=%0d exp 1 1 0 3", rd_ready, sram_ce, sram_rw, sram_addr); end
      tick();
      rd_valid = 1'b0;
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rsp_early got %b exp 0", rsp_valid); end
      vectors++; if (sram_ce !== 1'b0 || sram_addr !== '0) begin
         miscompares++; $display("FAIL idle_drive got ce=%b addr=%0d exp 0 0", sram_ce, sram_addr); end
      tick();
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rsp_latency got %b exp 1", rsp_valid); end
      vectors++; if (rsp_data !== exp_v) begin miscompares++; $display("FAIL rsp_a5 got %h exp %h", rsp_data, exp_v); end
      tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rsp_popped got %b exp 0", rsp_valid); end
      tick();
   endtask

   task automatic test_alternate();
      rsp_ready = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 8'd10; rd_addr = 8'd3;
      wr_data = pat(10);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vectors++;
         if (wr_ready !== (i % 2 == 0) || rd_ready !== (i % 2 == 1) || sram_ce !== 1'b1) begin
            miscompares++;
            $display("FAIL alternate_%0d got wr=%b rd=%b ce=%b exp wr=%0d rd=%0d ce=1",
                     i, wr_ready, rd_ready, sram_ce, i % 2 == 0, i % 2 == 1);
         end
         tick();
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      tick(); tick(); tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 8; a++) write_word(a);
      rsp_q.delete();
      rsp_ready = 1'b1; rd_valid = 1'b1;
      for (int a = 0; a < 8; a++) begin
         rd_addr = AWD'(a);
         @(negedge clk);
         vectors++; if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_grant_%0d got %b exp 1", a, rd_ready); end
         tick();
      end
      rd_valid = 1'b0;
      tick(); tick(); tick();
      vectors++; if (rsp_q.size() != 8) begin miscompares++; $display("FAIL b2b_count got %0d exp 8", rsp_q.size()); end
      for (int a = 0; a < 8 && a < rsp_q.size(); a++) begin
         vectors++; if (rsp_q[a] !== pat(a)) begin miscompares++; $display("FAIL b2b_data_%0d got %h exp %h", a, rsp_q[a], pat(a)); end
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_credit_stall();
      int   grants;
      vec_t held;
      grants = 0;
      rsp_q.delete();
      rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rd_ready) grants++;
         tick();
         rd_addr = AWD'(grants);
      end
      vectors++; if (grants != 2) begin miscompares++; $display("FAIL stall_grants got %0d exp 2", grants); end
      @(negedge clk);
      vectors++; if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL stall_rd_ready got %b exp 0", rd_ready); end
      vectors++; if (rsp_data !== pat(0)) begin miscompares++; $display("FAIL stall_head got %h exp %h", rsp_data, pat(0)); end
      held = rsp_data;
      tick();
      wr_valid = 1'b1; wr_addr = 8'd40; wr_data = pat(40);
      @(negedge clk);
      vectors++; if (rsp_data !== held || rsp_valid !== 1'b1) begin
         miscompares++; $display("FAIL stall_hold got v=%b %h exp v=1 %h", rsp_valid, rsp_data, held); end
      vectors++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
         miscompares++; $display("FAIL stall_write got wr=%b rd=%b exp wr=1 rd=0", wr_ready, rd_ready); end
      tick();
      wr_valid = 1'b0; rsp_ready = 1'b1;
      for (int c = 0; c < 20 && grants < 5; c++) begin
         @(negedge clk);
         if (rd_ready) grants++;
         tick();
         rd_addr = AWD'(grants);
      end
      rd_valid = 1'b0;
      vectors++; if (grants != 5) begin miscompares++; $display("FAIL resume_grants got %0d exp 5", grants); end
      tick(); tick(); tick(); tick();
      vectors++; if (rsp_q.size() != 5) begin miscompares++; $display("FAIL resume_count got %0d exp 5", rsp_q.size()); end
      for (int a = 0; a < 5 && a < rsp_q.size(); a++) begin
         vectors++; if (rsp_q[a] !== pat(a)) begin miscompares++; $display("FAIL resume_data_%0d got %h exp %h", a, rsp_q[a], pat(a)); end
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b1; rd_valid = 1'b1; rd_addr = 8'd5;
      @(negedge clk);
      vectors++; if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_read_grant got %b exp 1", rd_ready); end
      tick();
      rd_valid = 1'b0; rst = 1'b1; wr_valid = 1'b1; wr_addr = 8'd50; wr_data = pat(50);
      @(negedge clk);
      vectors++; if (wr_ready !== 1'b0 || sram_ce !== 1'b0) begin
         miscompares++; $display("FAIL mid_rst_gate got wr=%b ce=%b exp 0 0", wr_ready, sram_ce); end
      tick();
      rst = 1'b0; rd_valid = 1'b1;
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_discard got %b exp 0", rsp_valid); end
      vectors++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
         miscompares++; $display("FAIL mid_tie got wr=%b rd=%b exp wr=1 rd=0", wr_ready, rd_ready); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
         miscompares++; $display("FAIL wr_last_clear got wr=%b rd=%b exp wr=1 rd=0", wr_ready, rd_ready); end
      tick();
      wr_valid = 1'b0; rd_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_rsp_%0d got %b exp 0", c, rsp_valid); end
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_write_read();
      test_alternate();
      test_back_to_back();
      test_credit_stall();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
